// File: rtl/can_crc_engine_pkg.sv
// Shared types, default generator polynomials and width helpers for the CAN CRC engine.
package can_pkg;

  localparam int CRC_MAX_W = 21;

  localparam logic [14:0] POLY15_DEF = 15'h4599;
  localparam logic [16:0] POLY17_DEF = 17'h1685B;
  localparam logic [20:0] POLY21_DEF = 21'h102899;

  typedef enum logic [1:0] {
    CRC15 = 2'd0,
    CRC17 = 2'd1,
    CRC21 = 2'd2
  } crc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CRCF  = 2'd2,
    ST_DONE  = 2'd3
  } crc_state_e;

  // The reserved selector code falls back to classic CRC-15.
  function automatic crc_mode_e sel_to_mode(input logic [1:0] sel);
    case (sel)
      2'd1:    return CRC17;
      2'd2:    return CRC21;
      default: return CRC15;
    endcase
  endfunction

  function automatic logic [4:0] mode_width(input crc_mode_e mode);
    case (mode)
      CRC17:   return 5'd17;
      CRC21:   return 5'd21;
      default: return 5'd15;
    endcase
  endfunction

endpackage

// File: rtl/can_crc_engine_if.sv
// Bit-stream side of the CRC engine: framer/destuffer drives master, engine is slave.
interface can_crc_engine_if;
  import can_pkg::*;

  // Handshake: there is no back-pressure. A bit is consumed on every clock edge where
  // bit_valid is high, unless abort or start is also high in that cycle (abort > start > bit).
  logic                 start;
  logic [1:0]           crc_sel;
  logic                 abort;
  logic                 bit_valid;
  logic                 din;
  logic                 crc_field;
  logic [CRC_MAX_W-1:0] crc_out;
  logic                 tx_bit;
  logic                 busy;
  logic                 done;
  logic                 crc_ok;
  logic                 fmt_err;
  crc_state_e           dbg_state;

  modport master (
    output start, crc_sel, abort, bit_valid, din, crc_field,
    input  crc_out, tx_bit, busy, done, crc_ok, fmt_err, dbg_state
  );

  modport slave (
    input  start, crc_sel, abort, bit_valid, din, crc_field,
    output crc_out, tx_bit, busy, done, crc_ok, fmt_err, dbg_state
  );

endinterface

// File: rtl/can_crc_engine_step.sv
// Combinational one-bit CRC LFSR step for a W-bit register with implicit x^W term.
module can_crc_step #(
  parameter int           W    = 15,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic [W-1:0] crc,
  input  logic         din,
  output logic [W-1:0] crc_next
);

  logic feedback;

  assign feedback = din ^ crc[W-1];
  assign crc_next = {crc[W-2:0], 1'b0} ^ (feedback ? POLY : '0);

endmodule

// File: rtl/can_crc_engine.sv
// Multi-mode CAN CRC engine: accumulates frame bits, then serialises (TX) or checks (RX)
// the CRC field for CRC-15, CRC-17 or CRC-21 selected at frame start.
module can_crc_engine
  import can_pkg::*;
#(
  parameter logic [14:0] POLY15  = POLY15_DEF,
  parameter logic [16:0] POLY17  = POLY17_DEF,
  parameter logic [20:0] POLY21  = POLY21_DEF,
  parameter bit          FD_INIT = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  can_crc_engine_if.slave   bus
);

  crc_state_e           state_q, state_d;
  crc_mode_e            mode_q, mode_d;
  logic [CRC_MAX_W-1:0] crc_q, crc_d;
  logic [CRC_MAX_W-1:0] frozen_q, frozen_d;
  logic [4:0]           idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 fmt_err_q, fmt_err_d;

  logic [14:0]          nxt15;
  logic [16:0]          nxt17;
  logic [20:0]          nxt21;
  logic [CRC_MAX_W-1:0] crc_upd;
  logic [4:0]           width;
  logic [4:0]           msb_idx;
  logic [4:0]           idx_inc;
  crc_mode_e            sel_mode;

  function automatic logic [CRC_MAX_W-1:0] preset(input crc_mode_e mode);
    if (FD_INIT && mode == CRC17) return 21'h010000;
    if (FD_INIT && mode == CRC21) return 21'h100000;
    return '0;
  endfunction

  can_crc_step #(.W(15), .POLY(POLY15)) u_step15 (
    .crc(crc_q[14:0]), .din(bus.din), .crc_next(nxt15)
  );
  can_crc_step #(.W(17), .POLY(POLY17)) u_step17 (
    .crc(crc_q[16:0]), .din(bus.din), .crc_next(nxt17)
  );
  can_crc_step #(.W(21), .POLY(POLY21)) u_step21 (
    .crc(crc_q[20:0]), .din(bus.din), .crc_next(nxt21)
  );

  always_comb begin
    crc_upd = '0;
    unique case (mode_q)
      CRC17:   crc_upd = {4'b0, nxt17};
      CRC21:   crc_upd = nxt21;
      default: crc_upd = {6'b0, nxt15};
    endcase
  end

  assign sel_mode = sel_to_mode(bus.crc_sel);
  assign width    = mode_width(mode_q);
  assign msb_idx  = width - 5'd1;
  assign idx_inc  = idx_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= CRC15;
      crc_q     <= '0;
      frozen_q  <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      crc_q     <= crc_d;
      frozen_q  <= frozen_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    crc_d     = crc_q;
    frozen_d  = frozen_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    fmt_err_d = fmt_err_q;

    if (bus.abort) begin
      state_d   = ST_IDLE;
      crc_d     = '0;
      idx_d     = '0;
      crc_ok_d  = 1'b0;
      fmt_err_d = 1'b0;
    end else if (bus.start) begin
      state_d   = ST_ACCUM;
      mode_d    = sel_mode;
      crc_d     = preset(sel_mode);
      idx_d     = '0;
      crc_ok_d  = 1'b0;
      fmt_err_d = 1'b0;
    end else if (bus.bit_valid) begin
      unique case (state_q)
        ST_ACCUM: begin
          crc_d = crc_upd;
          if (bus.crc_field) begin
            // Freeze the transmit copy before the first CRC bit alters the remainder.
            frozen_d = crc_q;
            idx_d    = 5'd1;
            state_d  = ST_CRCF;
          end
        end
        ST_CRCF: begin
          if (bus.crc_field) begin
            crc_d = crc_upd;
            idx_d = idx_inc;
            if (idx_inc == width) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              crc_ok_d = (crc_upd == '0);
            end
          end else begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            crc_ok_d  = 1'b0;
            fmt_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.tx_bit = 1'b0;
    unique case (state_q)
      ST_ACCUM: bus.tx_bit = crc_q[msb_idx];
      ST_CRCF:  bus.tx_bit = frozen_q[msb_idx - idx_q];
      default:  bus.tx_bit = 1'b0;
    endcase
  end

  assign bus.crc_out   = crc_q;
  assign bus.busy      = (state_q == ST_ACCUM) || (state_q == ST_CRCF);
  assign bus.done      = done_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.fmt_err   = fmt_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_can_crc_engine.sv
// Directed bench for can_crc_engine: single-bit vector table plus full-frame sequences.
module tb_can_crc_engine;
  import can_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic exp_q[$];

  can_crc_engine_if bus();

  can_crc_engine dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sel);
    bus.start   = 1'b1;
    bus.crc_sel = sel;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic send(input logic d, input logic field);
    bus.bit_valid = 1'b1;
    bus.din       = d;
    bus.crc_field = field;
    tick();
    bus.bit_valid = 1'b0;
    bus.crc_field = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".crc_out"}, 32'(bus.crc_out), 32'h0);
    check({name, ".busy"},    32'(bus.busy),    32'h0);
    check({name, ".done"},    32'(bus.done),    32'h0);
    check({name, ".crc_ok"},  32'(bus.crc_ok),  32'h0);
    check({name, ".fmt_err"}, 32'(bus.fmt_err), 32'h0);
    check({name, ".tx_bit"},  32'(bus.tx_bit),  32'h0);
    check({name, ".state"},   32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  // Data bit, then a full CRC field of n bits taken from crc_val MSB-first.
  // flip >= 0 corrupts that CRC bit; use_tx feeds the engine's own tx_bit back as din.
  task automatic run_frame(input string name, input logic [1:0] sel, input logic data,
                           input int n, input logic [20:0] crc_val, input int flip,
                           input bit use_tx);
    logic d;
    logic e;
    do_start(sel);
    send(data, 1'b0);
    check({name, ".accum_crc"}, 32'(bus.crc_out), 32'(crc_val));
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(crc_val[n-1-k]);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s.tx_bit[%0d]", name, k), 32'(bus.tx_bit), 32'(e));
      check($sformatf("%s.no_done[%0d]", name, k), 32'(bus.done), 32'h0);
      d = use_tx ? bus.tx_bit : crc_val[n-1-k];
      if (k == flip) d = ~d;
      send(d, 1'b1);
    end
    check({name, ".done"},    32'(bus.done),    32'h1);
    check({name, ".crc_ok"},  32'(bus.crc_ok),  (flip < 0) ? 32'h1 : 32'h0);
    check({name, ".fmt_err"}, 32'(bus.fmt_err), 32'h0);
    check({name, ".busy"},    32'(bus.busy),    32'h0);
    if (flip < 0) check({name, ".crc_zero"}, 32'(bus.crc_out), 32'h0);
    tick();
    check({name, ".done_pulse"}, 32'(bus.done),   32'h0);
    check({name, ".ok_held"},    32'(bus.crc_ok), (flip < 0) ? 32'h1 : 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic        din;
    logic [20:0] exp_preset;
    logic [20:0] exp_crc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.crc_sel = 2'd0; bus.abort = 1'b0;
    bus.bit_valid = 1'b0; bus.din = 1'b0; bus.crc_field = 1'b0;

    vecs[0] = '{2'd0, 1'b1, 21'h0,      21'h004599};
    vecs[1] = '{2'd0, 1'b0, 21'h0,      21'h000000};
    vecs[2] = '{2'd1, 1'b1, 21'h010000, 21'h000000};
    vecs[3] = '{2'd1, 1'b0, 21'h010000, 21'h01685B};
    vecs[4] = '{2'd2, 1'b0, 21'h100000, 21'h102899};
    vecs[5] = '{2'd2, 1'b1, 21'h100000, 21'h000000};
    vecs[6] = '{2'd3, 1'b1, 21'h0,      21'h004599};
    vecs[7] = '{2'd3, 1'b0, 21'h0,      21'h000000};

    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Bits in IDLE are ignored.
    send(1'b1, 1'b0);
    check("idle_ignore.crc_out", 32'(bus.crc_out), 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_start(vecs[i].sel);
      check($sformatf("vec%0d.preset", i), 32'(bus.crc_out), 32'(vecs[i].exp_preset));
      check($sformatf("vec%0d.busy", i),   32'(bus.busy),    32'h1);
      send(vecs[i].din, 1'b0);
      check($sformatf("vec%0d.crc", i),    32'(bus.crc_out), 32'(vecs[i].exp_crc));
    end

    // Two-bit CRC-15 sequence.
    do_start(2'd0);
    send(1'b1, 1'b0);
    check("seq15.bit0", 32'(bus.crc_out), 32'h4599);
    send(1'b0, 1'b0);
    check("seq15.bit1", 32'(bus.crc_out), 32'h4EAB);

    // Full frames: RX good, RX corrupted, TX loopback on all three widths.
    run_frame("rx15",      2'd0, 1'b1, 15, 21'h004599, -1, 1'b0);
    run_frame("rx15_flip", 2'd0, 1'b1, 15, 21'h004599,  7, 1'b0);
    run_frame("tx15",      2'd0, 1'b1, 15, 21'h004599, -1, 1'b1);
    run_frame("tx17",      2'd1, 1'b0, 17, 21'h01685B, -1, 1'b1);
    run_frame("tx21",      2'd2, 1'b0, 21, 21'h102899, -1, 1'b1);

    // Bits after completion are ignored.
    send(1'b1, 1'b0);
    check("done_ignore.crc_out", 32'(bus.crc_out), 32'h0);
    check("done_ignore.state",   32'(bus.dbg_state), 32'(ST_DONE));

    // Abort after completion clears the held result.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("abort_done");

    // crc_field dropped after 5 CRC bits.
    do_start(2'd0);
    send(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    // The sixth bit above was a CRC bit; rebuild the frame with correct bits instead.
    do_start(2'd0);
    send(1'b1, 1'b0);
    begin
      logic [14:0] c;
      c = 15'h4599;
      for (int k = 0; k < 5; k++) send(c[14-k], 1'b1);
    end
    check("fmt.mid_crc",   32'(bus.crc_out), 32'h3320);
    check("fmt.state",     32'(bus.dbg_state), 32'(ST_CRCF));
    send(1'b1, 1'b0);
    check("fmt.done",      32'(bus.done),    32'h1);
    check("fmt.fmt_err",   32'(bus.fmt_err), 32'h1);
    check("fmt.crc_ok",    32'(bus.crc_ok),  32'h0);
    check("fmt.crc_held",  32'(bus.crc_out), 32'h3320);
    tick();
    check("fmt.done_pulse", 32'(bus.done),    32'h0);
    check("fmt.err_held",   32'(bus.fmt_err), 32'h1);
    do_start(2'd0);
    check("fmt.cleared_by_start", 32'(bus.fmt_err), 32'h0);

    // start and bit_valid together: the bit is dropped.
    bus.bit_valid = 1'b1;
    bus.din       = 1'b1;
    do_start(2'd2);
    bus.bit_valid = 1'b0;
    bus.din       = 1'b0;
    check("start_drop.crc_out", 32'(bus.crc_out), 32'h100000);

    // crc_sel changes outside start have no effect.
    do_start(2'd0);
    bus.crc_sel = 2'd2;
    send(1'b1, 1'b0);
    check("sel_latched.crc_out", 32'(bus.crc_out), 32'h4599);

    // Abort mid-ACCUM.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_idle_outputs("abort_accum");

    // Asynchronous reset mid-ACCUM, observed before any further clock edge.
    do_start(2'd0);
    send(1'b1, 1'b0);
    check("pre_rst.crc_out", 32'(bus.crc_out), 32'h4599);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
